// File: rtl/load_store_unit.sv
// load_store_unit: adapts RV64 b/h/w/d loads and stores to a doubleword memory, using read-modify-write for sub-doubleword stores.
// Define LSU_MISALIGN_TRAP_EN to answer misaligned requests with resp_err instead of aligning the offset down.
module load_store_unit #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_err,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_read_data
);
    localparam logic [1:0] IDLE = 2'd0, LOAD = 2'd1, RMW_RD = 2'd2, WRITE = 2'd3;
    logic [1:0]        state_q, state_d;
    logic [2:0]        f3_q, f3_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d, resp_data_q, resp_data_d;
    logic              resp_valid_q, resp_valid_d, resp_err_q, resp_err_d;
    logic              accept, trap;
    logic [2:0]        o;
    logic [5:0]        sh;
    logic [DATA_W-1:0] rd, ext, fmask, merged;

    assign req_ready = state_q == IDLE;
    assign accept    = req_valid && req_ready;
`ifdef LSU_MISALIGN_TRAP_EN
    assign trap = accept && ((req_funct3[1:0] == 2'b01 && req_addr[0])
                          || (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00)
                          || (req_funct3[1:0] == 2'b11 && req_addr[2:0] != 3'b000));
    assign o = addr_q[2:0];
`else
    assign trap = 1'b0;
    // Misaligned accesses silently fall back to the naturally aligned field
    assign o = addr_q[2:0] & (f3_q[1:0] == 2'b00 ? 3'b111
                            : f3_q[1:0] == 2'b01 ? 3'b110
                            : f3_q[1:0] == 2'b10 ? 3'b100 : 3'b000);
`endif

    always_comb begin
        sh     = {o, 3'b000};
        rd     = mem_read_data >> sh;
        ext    = f3_q == 3'b000 ? {{(DATA_W-8){rd[7]}}, rd[7:0]}
               : f3_q == 3'b001 ? {{(DATA_W-16){rd[15]}}, rd[15:0]}
               : f3_q == 3'b010 ? {{(DATA_W-32){rd[31]}}, rd[31:0]}
               : f3_q == 3'b100 ? {{(DATA_W-8){1'b0}}, rd[7:0]}
               : f3_q == 3'b101 ? {{(DATA_W-16){1'b0}}, rd[15:0]}
               : f3_q == 3'b110 ? {{(DATA_W-32){1'b0}}, rd[31:0]}
               : rd;
        fmask  = f3_q[1:0] == 2'b00 ? {{(DATA_W-8){1'b0}}, {8{1'b1}}}
               : f3_q[1:0] == 2'b01 ? {{(DATA_W-16){1'b0}}, {16{1'b1}}}
               : f3_q[1:0] == 2'b10 ? {{(DATA_W-32){1'b0}}, {32{1'b1}}}
               : {DATA_W{1'b1}};
        merged = (mem_read_data & ~(fmask << sh)) | ((wdata_q & fmask) << sh);
        state_d = state_q == RMW_RD ? WRITE
                : accept && !trap ? (!req_write ? LOAD : req_funct3[1:0] == 2'b11 ? WRITE : RMW_RD)
                : IDLE;
        f3_d         = accept ? req_funct3 : f3_q;
        addr_d       = accept ? req_addr : addr_q;
        wdata_d      = state_q == RMW_RD ? merged : accept ? req_wdata : wdata_q;
        resp_valid_d = trap || state_q == LOAD || state_q == WRITE;
        resp_err_d   = trap;
        resp_data_d  = state_q == LOAD ? ext : '0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            f3_q         <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            f3_q         <= f3_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_data_q  <= resp_data_d;
        end
    end

    assign mem_read       = state_q == LOAD || state_q == RMW_RD;
    assign mem_write      = state_q == WRITE;
    assign mem_address    = {addr_q[ADDR_W-1:3], 3'b000};
    assign mem_write_data = wdata_q;
    assign resp_valid     = resp_valid_q;
    assign resp_data      = resp_data_q;
    assign resp_err       = resp_err_q;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed stimulus with a response scoreboard against a small doubleword memory.
module tb_load_store_unit;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0, req_write = 1'b0;
    logic [2:0]  req_funct3 = '0;
    logic [63:0] req_addr = '0, req_wdata = '0;
    logic        req_ready, resp_valid, resp_err, mem_read, mem_write;
    logic [63:0] resp_data, mem_address, mem_write_data, mem_read_data;

    load_store_unit dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [63:0] data;
        logic        err;
        int          cyc;
    } exp_t;
    exp_t q[$];
    exp_t mon_e;
    int checks = 0, failures = 0;
    int cyc = 0, rd_cnt = 0, wr_cnt = 0;

    logic [63:0] mem [0:7];
    logic        pl_en = 1'b0;
    logic [2:0]  pl_idx = '0;
    logic [63:0] pl_val = '0;
    always @(posedge clock) begin
        if (pl_en) mem[pl_idx] <= pl_val;
        else if (mem_write) mem[mem_address[5:3]] <= mem_write_data;
    end
    assign mem_read_data = mem[mem_address[5:3]];

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (!reset && mem_read) rd_cnt <= rd_cnt + 1;
        if (!reset && mem_write) wr_cnt <= wr_cnt + 1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (mem_read || mem_write) chk("rw_exclusive", {63'b0, mem_read & mem_write}, 64'd0);
        if (!reset && resp_valid) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_resp actual=%h expected=none", resp_data);
            end else begin
                mon_e = q.pop_front();
                chk("resp_data", resp_data, mon_e.data);
                chk("resp_err", {63'b0, resp_err}, {63'b0, mon_e.err});
                chk("resp_cycle", 64'(cyc), 64'(mon_e.cyc));
            end
        end
    end

    task automatic preload(input logic [2:0] idx, input logic [63:0] val);
        pl_en = 1'b1;
        pl_idx = idx;
        pl_val = val;
        @(negedge clock);
        pl_en = 1'b0;
    endtask

    task automatic issue(input logic w, input logic [2:0] f3, input logic [63:0] a, input logic [63:0] wd,
                         input logic [63:0] ed, input logic ee, input int lat, input bit push, output int acc);
        int n = 0;
        req_valid = 1'b1;
        req_write = w;
        req_funct3 = f3;
        req_addr = a;
        req_wdata = wd;
        while (!req_ready && n < 20) begin
            @(negedge clock);
            n++;
        end
        if (n >= 20) begin
            checks++;
            failures++;
            $display("FAIL req_ready_timeout actual=0 expected=1");
        end
        acc = cyc;
        if (push) q.push_back('{ed, ee, cyc + lat});
        @(negedge clock);
        req_valid = 1'b0;
        req_wdata = 64'hDEAD_DEAD_DEAD_DEAD;
        req_addr = 64'h38;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (n >= 50) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout actual=%0d expected=0", q.size());
        end
    endtask

    task automatic chk_reset_outputs();
        chk("rst_req_ready", {63'b0, req_ready}, 64'd1);
        chk("rst_resp_valid", {63'b0, resp_valid}, 64'd0);
        chk("rst_resp_err", {63'b0, resp_err}, 64'd0);
        chk("rst_resp_data", resp_data, 64'd0);
        chk("rst_mem_read", {63'b0, mem_read}, 64'd0);
        chk("rst_mem_write", {63'b0, mem_write}, 64'd0);
        chk("rst_mem_address", mem_address, 64'd0);
        chk("rst_mem_write_data", mem_write_data, 64'd0);
    endtask

    initial begin
        int acc, acc2, r0, w0;
        for (int i = 0; i < 8; i++) preload(3'(i), 64'd0);
        preload(3'd1, 64'h8877665544332211);
        preload(3'd3, 64'h1111111111111111);
        chk_reset_outputs();
        reset = 1'b0;
        @(negedge clock);
        issue(1'b0, 3'b000, 64'h0F, 64'd0, 64'hFFFFFFFFFFFFFF88, 1'b0, 2, 1'b1, acc);
        issue(1'b0, 3'b100, 64'h0F, 64'd0, 64'h88, 1'b0, 2, 1'b1, acc);
        issue(1'b0, 3'b010, 64'h0C, 64'd0, 64'hFFFFFFFF88776655, 1'b0, 2, 1'b1, acc);
        issue(1'b0, 3'b110, 64'h0C, 64'd0, 64'h88776655, 1'b0, 2, 1'b1, acc);
        issue(1'b0, 3'b011, 64'h08, 64'd0, 64'h8877665544332211, 1'b0, 2, 1'b1, acc);
        issue(1'b0, 3'b111, 64'h08, 64'd0, 64'h8877665544332211, 1'b0, 2, 1'b1, acc);
        issue(1'b0, 3'b001, 64'h0E, 64'd0, 64'hFFFFFFFFFFFF8877, 1'b0, 2, 1'b1, acc);
        issue(1'b0, 3'b101, 64'h0E, 64'd0, 64'h8877, 1'b0, 2, 1'b1, acc);
        drain();
        r0 = rd_cnt;
        w0 = wr_cnt;
        issue(1'b1, 3'b001, 64'h0A, 64'hBEEF, 64'd0, 1'b0, 3, 1'b1, acc);
        drain();
        chk("sh_reads", 64'(rd_cnt - r0), 64'd1);
        chk("sh_writes", 64'(wr_cnt - w0), 64'd1);
        chk("sh_mem1", mem[1], 64'h88776655BEEF2211);
        issue(1'b1, 3'b000, 64'h09, 64'h123456789ABCDEAB, 64'd0, 1'b0, 3, 1'b1, acc);
        issue(1'b1, 3'b110, 64'h04, 64'hFFFFFFFFCAFEF00D, 64'd0, 1'b0, 3, 1'b1, acc);
        drain();
        chk("sb_mem1", mem[1], 64'h88776655BEEFAB11);
        chk("sw_mem0", mem[0], 64'hCAFEF00D00000000);
        issue(1'b1, 3'b011, 64'h10, 64'h0123456789ABCDEF, 64'd0, 1'b0, 2, 1'b1, acc);
        issue(1'b0, 3'b011, 64'h10, 64'd0, 64'h0123456789ABCDEF, 1'b0, 2, 1'b1, acc2);
        chk("b2b_accept_gap", 64'(acc2 - acc), 64'd2);
        drain();
        chk("sd_mem2", mem[2], 64'h0123456789ABCDEF);
        r0 = rd_cnt;
`ifdef LSU_MISALIGN_TRAP_EN
        issue(1'b0, 3'b010, 64'h0A, 64'd0, 64'd0, 1'b1, 1, 1'b1, acc);
        drain();
        chk("trap_no_read", 64'(rd_cnt - r0), 64'd0);
`else
        issue(1'b0, 3'b010, 64'h0A, 64'd0, 64'hFFFFFFFFBEEFAB11, 1'b0, 2, 1'b1, acc);
        drain();
        chk("misalign_one_read", 64'(rd_cnt - r0), 64'd1);
`endif
        issue(1'b1, 3'b000, 64'h18, 64'hCC, 64'd0, 1'b0, 3, 1'b0, acc);
        @(negedge clock);
        chk("rst_in_write", {63'b0, mem_write}, 64'd1);
        #2 reset = 1'b1;
        #1 chk_reset_outputs();
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (4) @(negedge clock);
        chk("rst_mem3_kept", mem[3], 64'h1111111111111111);
        chk("rst_queue_empty", 64'(q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
